// File: rtl/disk_sector_server.sv
// disk_sector_server: services wd1770 sector read/write commands against a byte-addressed disk-image memory
module disk_sector_server #(
  parameter int ADDR_W = 24,
  parameter logic [ADDR_W-1:0] DRV1_BASE = 24'h100000,
  parameter int NSECT = 10,
  parameter int NTRK = 80,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       dsr,
  output logic [31:0]       dcr,
  output logic [7:0]        dd_out,
  output logic              dd_outclk,
  input  logic [7:0]        dd_in,
  output logic              dd_inclk,
  input  logic [1:0]        wp,
  input  logic [1:0]        ins,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, RD_REQ = 3'd2, RD_WAIT = 3'd3,
                         WR_PULL = 3'd4, WR_REQ = 3'd5, WR_WAIT = 3'd6, ACK = 3'd7;
  logic [2:0] state;
  logic drv, wr, side;
  logic [6:0] trk;
  logic [4:0] sect;
  logic [ADDR_W-1:0] addr;
  logic [9:0] cnt;
  logic [TW-1:0] tcnt;
  logic [11:0] ts_n, lin;
  logic bad, last;
  logic [3:0] cmdb;
  logic unused_dsr;
  assign cmdb = {dsr[21], dsr[20], dsr[18], dsr[17]};
  assign unused_dsr = ^{dsr[31:22], dsr[19], dsr[16:13]};
  assign busy = state != IDLE;
  assign dd_inclk = state == WR_PULL;
  assign last = cnt == 10'd511;
  // track*2+side times NSECT built from shifted copies, one per set bit of NSECT
  always_comb begin
    ts_n = '0;
    for (int i = 0; i < 5; i++) ts_n = ts_n + (NSECT[i] ? ({4'b0, trk, side} << i) : 12'd0);
    lin = ts_n + {7'b0, sect} - 12'd1;
    bad = !ins[drv] || sect == 5'd0 || 32'(sect) > NSECT || 32'(trk) >= NTRK || (wr && wp[drv]);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      dcr <= '0;
      dd_out <= '0;
      dd_outclk <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      tcnt <= '0;
      drv <= 1'b0;
      wr <= 1'b0;
      side <= 1'b0;
      trk <= '0;
      sect <= '0;
      addr <= '0;
    end else begin
      dd_outclk <= 1'b0;
      case (state)
        IDLE: if (|cmdb && !dcr[4]) begin
          drv <= !dsr[17] && (dsr[18] || !dsr[20]);
          wr <= !(dsr[17] || dsr[18]);
          side <= dsr[12];
          trk <= dsr[11:5];
          sect <= dsr[4:0];
          state <= DECODE;
        end
        DECODE: begin
          cnt <= '0;
          addr <= (drv ? DRV1_BASE : '0) + ADDR_W'({lin, 9'b0});
          dcr <= bad ? 32'h18 : 32'h0;
          state <= bad ? ACK : (wr ? WR_PULL : RD_REQ);
        end
        RD_REQ, WR_REQ: begin
          mem_addr <= addr + ADDR_W'(cnt);
          mem_rd <= state == RD_REQ;
          mem_wr <= state == WR_REQ;
          tcnt <= '0;
          state <= state == RD_REQ ? RD_WAIT : WR_WAIT;
        end
        RD_WAIT, WR_WAIT: if (mem_ack) begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          cnt <= cnt + 10'd1;
          dd_out <= state == RD_WAIT ? mem_rdata : dd_out;
          dd_outclk <= state == RD_WAIT;
          dcr <= last ? 32'h10 : 32'h0;
          state <= last ? ACK : (state == RD_WAIT ? RD_REQ : WR_PULL);
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          dcr <= 32'h18;
          state <= ACK;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        WR_PULL: begin
          mem_wdata <= dd_in;
          state <= WR_REQ;
        end
        ACK: if (!(|cmdb)) begin
          dcr <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_disk_sector_server.sv
// tb_disk_sector_server: directed checks of sector reads, writes, error paths, timeout and mid-transfer reset
module tb_disk_sector_server;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] dsr = '0;
  logic [31:0] dcr;
  logic [7:0] dd_out, dd_in, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic dd_outclk, dd_inclk, mem_rd, mem_wr, busy;
  logic mem_ack = 1'b0;
  logic [1:0] wp = 2'b00, ins = 2'b11;
  logic [23:0] mem_addr;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  disk_sector_server dut (
    .clk(clk), .rstn(rstn), .dsr(dsr), .dcr(dcr), .dd_out(dd_out), .dd_outclk(dd_outclk),
    .dd_in(dd_in), .dd_inclk(dd_inclk), .wp(wp), .ins(ins), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );
  logic [7:0] fifo [0:1023];
  int fifo_ptr = 0;
  assign dd_in = fifo[fifo_ptr[9:0]];
  int acks = 0, ack_lim = -1;
  logic [7:0] mem_img [int];
  logic [23:0] wlog [$];
  // memory answers one cycle after a request appears; data = low address byte; ack_lim stalls it
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if ((mem_rd || mem_wr) && !mem_ack && (ack_lim < 0 || acks < ack_lim)) begin
      mem_ack <= 1'b1;
      mem_rdata <= mem_addr[7:0];
      acks <= acks + 1;
      if (mem_wr) begin
        mem_img[int'(mem_addr)] = mem_wdata;
        wlog.push_back(mem_addr);
      end
    end
    if (dd_inclk) fifo_ptr <= fifo_ptr + 1;
  end
  int n_pop = 0, n_act = 0, n_rdhi = 0, n_both = 0;
  logic [7:0] outq [$];
  logic [23:0] raddr [$];
  always @(negedge clk) begin
    if (dd_outclk) outq.push_back(dd_out);
    if (dd_inclk) n_pop++;
    if (mem_rd || mem_wr || dd_outclk || dd_inclk) n_act++;
    if (mem_rd) n_rdhi++;
    if (mem_rd && mem_wr) n_both++;
    if (mem_rd && mem_ack) raddr.push_back(mem_addr);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input int op, input int sd, input int tr, input int sc);
    return (32'd1 << op) | (32'(sd) << 12) | (32'(tr) << 5) | 32'(sc);
  endfunction
  function automatic logic [31:0] all_out();
    return dcr | 32'(mem_addr) | {16'b0, mem_wdata, dd_out} | 32'({dd_outclk, dd_inclk, mem_rd, mem_wr, busy});
  endfunction
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] exp, input string tag);
    int n = 0;
    dsr = cmd;
    while (!dcr[4] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ack"}, 32'(n < 20000), 1);
    check({tag, " dcr"}, dcr, exp);
    dsr = '0;
    @(negedge clk);
    check({tag, " clr"}, {dcr[30:0], busy}, 0);
  endtask
  initial begin
    int s, a, p, w, bad, n;
    logic [31:0] ecmd [5];
    for (int i = 0; i < 1024; i++) fifo[i] = i[0] ? 8'h5A : 8'hA5;
    repeat (3) @(negedge clk);
    check("reset outs", all_out(), 0);
    rstn = 1'b1;
    @(negedge clk);
    s = outq.size(); a = raddr.size();
    run_cmd(mk(17, 0, 0, 1), 32'h10, "rd0");
    check("rd0 count", outq.size() - s, 512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (outq[s+i] !== 8'(i) || raddr[a+i] !== 24'(i)) bad++;
    check("rd0 data", bad, 0);
    s = outq.size(); a = raddr.size();
    run_cmd(mk(18, 1, 5, 10), 32'h10, "rd1");
    check("rd1 count", outq.size() - s, 512);
    check("rd1 first", raddr[a], 24'h10EE00);
    check("rd1 last", raddr[a+511], 24'h10EFFF);
    p = n_pop; w = wlog.size(); s = fifo_ptr;
    run_cmd(mk(20, 0, 2, 3), 32'h10, "wr0");
    check("wr0 pops", n_pop - p, 512);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (wlog[w+i] !== 24'h5400 + 24'(i) || mem_img[32'h5400 + i] !== fifo[(s + i) % 1024]) bad++;
    check("wr0 data", bad, 0);
    ecmd = '{mk(20, 0, 0, 1), mk(17, 0, 0, 0), mk(17, 0, 0, 11), mk(17, 0, 80, 1), mk(18, 0, 0, 1)};
    for (int i = 0; i < 5; i++) begin
      wp = (i == 0) ? 2'b01 : 2'b00;
      ins = (i == 4) ? 2'b01 : 2'b11;
      p = n_act;
      run_cmd(ecmd[i], 32'h18, $sformatf("err%0d", i));
      check($sformatf("err%0d activity", i), n_act - p, 0);
    end
    wp = 2'b00; ins = 2'b11;
    s = outq.size(); p = n_rdhi;
    ack_lim = acks + 100;
    run_cmd(mk(17, 0, 1, 1), 32'h18, "tmo");
    ack_lim = -1;
    check("tmo count", outq.size() - s, 100);
    check("tmo rd cycles", n_rdhi - p, 200 + 4095);
    s = outq.size(); p = n_pop;
    run_cmd(mk(17, 0, 0, 1) | mk(21, 0, 0, 1), 32'h10, "prio");
    check("prio reads", outq.size() - s, 512);
    check("prio pops", n_pop - p, 0);
    p = n_pop; n = 0;
    dsr = mk(20, 0, 3, 4);
    while (n_pop - p < 200 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rst reach", n_pop - p, 200);
    rstn = 1'b0;
    dsr = '0;
    @(negedge clk);
    check("rst outs", all_out(), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst idle", all_out(), 0);
    s = outq.size(); a = raddr.size();
    run_cmd(mk(17, 0, 0, 2), 32'h10, "rd post");
    check("rd post count", outq.size() - s, 512);
    check("rd post first", raddr[a], 24'h000200);
    check("onehot req", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
